regfile_dump: RTL and testbench
===============================

# regfile_dump

Debug-unit sequencer that reads the entire 32-entry register file through its debug read port and streams the contents out as bytes. It drives the register file's debug address input, samples the debug read data, and serializes each 32-bit word MSB-first onto a valid/ready byte stream feeding the debug UART transmitter. It sits in the debug unit, between the ID-stage register file and the TX path. It is only triggered while the pipeline is halted.

## Interface
- NUM_REGS, 32: number of registers dumped, indices 0..NUM_REGS-1.
- ADDR_W, 5: width of the register index.
- DATA_W, 32: register width; must be a multiple of 8.

- clk  in  1  clock; all state updates on rising edge. One clock; reset is synchronous and active-high.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a full dump; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last byte is accepted.
- du_reg_addr  out  ADDR_W  debug read index to the register file.
- du_reg_data  in  DATA_W  combinational debug read data from the register file; register 0 reads as 0.
- tx_data  out  8  current byte.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  consumer accepts the byte when tx_valid && tx_ready at a rising edge.

## Operation
- The FSM has four states: IDLE, LOAD, SEND and DONE.
- State registers:
  - idx (ADDR_W): register index.
  - shreg (DATA_W): shift register holding the current word.
  - bcnt (2 bits for DATA_W=32): count of bytes sent from the current word.
- Output assignments:
  - du_reg_addr = idx at all times.
  - tx_data = shreg[DATA_W-1 -: 8].
  - tx_valid = (state == SEND).
- IDLE:
  - On start=1, set idx←0 and go to LOAD.
  - On start=0, stay in IDLE.
- LOAD:
  - Set shreg←du_reg_data and bcnt←0, then go to SEND.
  - No handshake takes place in LOAD.
- SEND, on a handshake:
  - If bcnt < DATA_W/8-1: shreg←shreg<<8, bcnt++.
  - Else if idx == NUM_REGS-1: go to DONE.
  - Else: idx++ and go to LOAD.
- SEND without a handshake: hold all state. tx_data is stable while tx_valid && !tx_ready.
- DONE: done=1 for this single cycle, then go to IDLE.
- Byte order: each word goes out big-endian, and registers go out in ascending order. Total stream is NUM_REGS*DATA_W/8 = 128 bytes.
- start while busy is ignored and is not queued. start held high continuously re-triggers a new dump from IDLE after each DONE.
- The dump is not atomic across registers. Each word is the value present at its LOAD edge. The register file writes on the falling edge, so the sampled value is the post-write value of the preceding negedge.

## Timing
- Reset values:
  - state=IDLE, idx=0, shreg=0, bcnt=0.
  - busy=0, done=0, tx_valid=0, tx_data=0, du_reg_addr=0.
- Reset asserted mid-dump:
  - At the next rising edge all of the above values are restored.
  - tx_valid drops without a handshake, and the partial stream is abandoned.
  - No done pulse is generated.
- Latency with the start edge at cycle 0:
  - LOAD in cycle 1.
  - First tx_valid in cycle 2.
- Per register, with tx_ready held at 1: 1 LOAD cycle plus 4 SEND cycles, so one bubble cycle between words.
- Full dump with tx_ready=1: 160 busy cycles before DONE, then the done pulse in cycle 161, then IDLE in cycle 162.
- Backpressure stalls only SEND. du_reg_addr is stable throughout SEND.

## Structure
- Shared debug package contains:
  - the state enum {IDLE, LOAD, SEND, DONE};
  - the NUM_REGS, ADDR_W and DATA_W defaults;
  - the BYTES_PER_WORD constant.
- No sub-module. The serializer is small and stays inline.

## Test plan
- Reset, then idle 10 cycles:
  - busy=0, done=0, tx_valid=0, du_reg_addr=0 throughout.
  - No bytes emitted.
- Register file preloaded with reg[i] = 0xA0B0C000+i (reg0 reads 0), tx_ready=1, start pulse:
  - Exactly 128 bytes are emitted.
  - The stream begins 00 00 00 00 A0 B0 C0 01 and ends A0 B0 C0 1F.
  - done pulses in cycle 161.
- Random tx_ready at 30% duty:
  - The same 128-byte sequence is emitted.
  - tx_data never changes while tx_valid=1 and tx_ready=0.
- start re-pulsed at cycles 5 and 50 of a dump:
  - Both pulses are ignored.
  - Exactly one done and 128 bytes.
- reset asserted while sending byte 2 of reg 7:
  - One edge later: tx_valid=0, busy=0, du_reg_addr=0.
  - A subsequent start produces a full dump from reg 0.
- reg5 written via write_enable during the dump, before idx reaches 5: the dumped reg5 bytes equal the new value.

Source files
------------

// File: rtl/regfile_dump_pkg.sv
// Shared definitions for the debug-unit register file dump sequencer:
// FSM state encoding, default geometry and byte-count helpers.
package regfile_dump_pkg;

    localparam int NUM_REGS_DEF   = 32;
    localparam int ADDR_W_DEF     = 5;
    localparam int DATA_W_DEF     = 32;
    localparam int BYTES_PER_WORD = DATA_W_DEF / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } dump_state_t;

    // Width of a counter that must hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/regfile_dump.sv
// Reads every register through the debug read port and streams each word
// MSB-first as bytes on a valid/ready interface towards the debug UART.
module regfile_dump
    import regfile_dump_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] du_reg_addr,
    input  logic [DATA_W-1:0] du_reg_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);

    localparam int BPW    = DATA_W / 8;
    localparam int BCNT_W = cnt_width(BPW);

    localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BPW - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);

    dump_state_t       state_reg, state_next;
    logic [ADDR_W-1:0] idx_reg, idx_next;
    logic [DATA_W-1:0] shreg_reg, shreg_next;
    logic [BCNT_W-1:0] bcnt_reg, bcnt_next;
    logic              handshake;

    assign du_reg_addr = idx_reg;
    assign tx_data     = shreg_reg[DATA_W-1 -: 8];
    assign tx_valid    = (state_reg == SEND);
    assign busy        = (state_reg != IDLE);
    assign done        = (state_reg == DONE);
    assign handshake   = tx_valid && tx_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            shreg_reg <= '0;
            bcnt_reg  <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            shreg_reg <= shreg_next;
            bcnt_reg  <= bcnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        shreg_next = shreg_reg;
        bcnt_next  = bcnt_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    idx_next   = '0;
                    state_next = LOAD;
                end
            end
            // Word is captured here so the address has a full cycle to settle.
            LOAD: begin
                shreg_next = du_reg_data;
                bcnt_next  = '0;
                state_next = SEND;
            end
            SEND: begin
                if (handshake) begin
                    if (bcnt_reg < LAST_BYTE) begin
                        shreg_next = shreg_reg << 8;
                        bcnt_next  = bcnt_reg + 1'b1;
                    end else if (idx_reg == LAST_IDX) begin
                        state_next = DONE;
                    end else begin
                        idx_next   = idx_reg + 1'b1;
                        state_next = LOAD;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump: table of dump scenarios against a
// byte-stream reference model, plus reset/idle and mid-dump reset sequences.
module tb_regfile_dump;

    localparam int NREGS  = 32;
    localparam int NBYTES = NREGS * 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        busy;
    logic        done;
    logic [4:0]  du_reg_addr;
    logic [31:0] du_reg_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    // Register file model: combinational read, falling-edge write, r0 = 0.
    logic [31:0] rf [NREGS];
    logic        write_enable;
    logic [4:0]  write_addr;
    logic [31:0] write_data;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   done_cnt = 0;
    int   done_rel = -1;
    int   first_valid_rel = -1;
    bit   prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] got [$];

    typedef struct {
        int ready_pct;
        bit rand_data;
        bit repulse;
        bit wr5;
        int exp_dones;
        int exp_done_rel;   // -1: latency depends on random backpressure
    } vec_t;

    vec_t vecs [5];

    regfile_dump dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .du_reg_addr (du_reg_addr),
        .du_reg_data (du_reg_data),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign du_reg_data = (du_reg_addr == 5'd0) ? 32'h0 : rf[du_reg_addr];

    always @(negedge clk) begin
        if (write_enable) rf[write_addr] = write_data;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Stream monitor, sampled mid-cycle when all signals are settled.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (tx_valid && prev_stall) chk("stall_hold", {24'h0, tx_data}, {24'h0, prev_data});
            if (tx_valid && first_valid_rel < 0) first_valid_rel = cyc - start_cyc;
            if (tx_valid && tx_ready) got.push_back(tx_data);
            if (done) begin
                done_cnt++;
                done_rel = cyc - start_cyc;
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic pick_ready(input int pct);
        return ($urandom_range(99) < pct);
    endfunction

    // Reference: word j/4 (register 0 reads zero), big-endian within the word.
    function automatic logic [7:0] exp_byte(input int j);
        logic [31:0] w;
        int r;
        r = j / 4;
        w = (r == 0) ? 32'h0 : rf[r];
        return w[8*(3 - (j % 4)) +: 8];
    endfunction

    task automatic run_dump(input vec_t v);
        got.delete();
        done_cnt        = 0;
        done_rel        = -1;
        first_valid_rel = -1;
        write_addr      = 5'd5;
        write_data      = $urandom;
        tick();
        start     = 1'b1;
        start_cyc = cyc;
        tx_ready  = pick_ready(v.ready_pct);
        for (int k = 1; k <= 4000; k++) begin
            tick();
            start        = v.repulse && (k == 5 || k == 50);
            tx_ready     = pick_ready(v.ready_pct);
            write_enable = v.wr5 && (k == 20);
            if (done_cnt > 0 && (cyc - start_cyc) >= done_rel + 4) break;
        end
        start        = 1'b0;
        tx_ready     = 1'b0;
        write_enable = 1'b0;
    endtask

    initial begin
        vecs[0] = '{ready_pct: 100, rand_data: 1'b0, repulse: 1'b0, wr5: 1'b0, exp_dones: 1, exp_done_rel: 161};
        vecs[1] = '{ready_pct: 30,  rand_data: 1'b0, repulse: 1'b0, wr5: 1'b0, exp_dones: 1, exp_done_rel: -1};
        vecs[2] = '{ready_pct: 100, rand_data: 1'b1, repulse: 1'b1, wr5: 1'b0, exp_dones: 1, exp_done_rel: 161};
        vecs[3] = '{ready_pct: 100, rand_data: 1'b0, repulse: 1'b0, wr5: 1'b1, exp_dones: 1, exp_done_rel: 161};
        vecs[4] = '{ready_pct: 30,  rand_data: 1'b1, repulse: 1'b1, wr5: 1'b1, exp_dones: 1, exp_done_rel: -1};

        reset        = 1'b1;
        start        = 1'b0;
        tx_ready     = 1'b0;
        write_enable = 1'b0;
        write_addr   = 5'd0;
        write_data   = 32'h0;
        for (int i = 0; i < NREGS; i++) rf[i] = 32'hA0B0_C000 + 32'(i);
        repeat (3) tick();
        reset = 1'b0;

        // Idle after reset: nothing moves.
        chk("reset_tx_data", {24'h0, tx_data}, 32'h0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_busy", {31'h0, busy}, 32'h0);
            chk("idle_done", {31'h0, done}, 32'h0);
            chk("idle_tx_valid", {31'h0, tx_valid}, 32'h0);
            chk("idle_addr", {27'h0, du_reg_addr}, 32'h0);
        end
        chk("idle_bytes", 32'(got.size()), 32'h0);

        foreach (vecs[vi]) begin
            for (int i = 0; i < NREGS; i++)
                rf[i] = vecs[vi].rand_data ? $urandom : 32'hA0B0_C000 + 32'(i);
            run_dump(vecs[vi]);
            $display("dump %0d: ready=%0d%% bytes=%0d dones=%0d done_rel=%0d first_valid=%0d",
                     vi, vecs[vi].ready_pct, got.size(), done_cnt, done_rel, first_valid_rel);
            chk("done_count", 32'(done_cnt), 32'(vecs[vi].exp_dones));
            chk("byte_count", 32'(got.size()), 32'(NBYTES));
            chk("first_valid_latency", 32'(first_valid_rel), 32'd2);
            if (vecs[vi].exp_done_rel >= 0)
                chk("done_latency", 32'(done_rel), 32'(vecs[vi].exp_done_rel));
            if (got.size() == NBYTES) begin
                for (int j = 0; j < NBYTES; j++)
                    chk($sformatf("byte[%0d]", j), {24'h0, got[j]}, {24'h0, exp_byte(j)});
                if (!vecs[vi].rand_data && !vecs[vi].wr5) begin
                    chk("stream_head", {got[4], got[5], got[6], got[7]}, 32'hA0B0_C001);
                    chk("stream_tail", {got[124], got[125], got[126], got[127]}, 32'hA0B0_C01F);
                end
            end
        end

        // Reset while byte 2 of register 7 is on the bus.
        for (int i = 0; i < NREGS; i++) rf[i] = 32'hA0B0_C000 + 32'(i);
        got.delete();
        done_cnt = 0;
        tick();
        start     = 1'b1;
        start_cyc = cyc;
        tx_ready  = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 400 && got.size() < 30; k++) tick();
        chk("mid_reset_reached", 32'(got.size()), 32'd30);
        chk("mid_reset_byte", {24'h0, tx_data}, 32'h0000_00C0);
        chk("mid_reset_addr_before", {27'h0, du_reg_addr}, 32'd7);
        reset = 1'b1;
        tick();
        chk("mid_reset_tx_valid", {31'h0, tx_valid}, 32'h0);
        chk("mid_reset_busy", {31'h0, busy}, 32'h0);
        chk("mid_reset_addr", {27'h0, du_reg_addr}, 32'h0);
        chk("mid_reset_tx_data", {24'h0, tx_data}, 32'h0);
        reset    = 1'b0;
        tx_ready = 1'b0;
        tick();
        chk("mid_reset_no_done", 32'(done_cnt), 32'h0);
        chk("mid_reset_partial", 32'(got.size()), 32'd30);
        $display("mid-dump reset: %0d bytes before abort", got.size());

        run_dump(vecs[0]);
        $display("restart dump: bytes=%0d dones=%0d done_rel=%0d", got.size(), done_cnt, done_rel);
        chk("restart_done_count", 32'(done_cnt), 32'd1);
        chk("restart_byte_count", 32'(got.size()), 32'(NBYTES));
        if (got.size() == NBYTES) begin
            for (int j = 0; j < NBYTES; j++)
                chk($sformatf("restart_byte[%0d]", j), {24'h0, got[j]}, {24'h0, exp_byte(j)});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
